muldiv_engine: RTL and testbench

//  Iterative signed MULT/DIV unit for the multicycle CPU; consumes A/B register values, produces HI/LO.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_engine_div_step.sv | 17 +
 rtl/muldiv_engine.sv | 162 ++++++++++++++++
 tb/tb_muldiv_engine.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative MULT/DIV engine: default widths, FSM encoding
// and cycle latencies counted from the accepting clock edge.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam int MULT_LAT  = WIDTH_DEF + 1;
    localparam int DIV_LAT   = WIDTH_DEF + 2;
    localparam int DIVZ_LAT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MULT   = 3'd1,
        ST_DIV    = 3'd2,
        ST_FIXUP  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;
endpackage

// File: rtl/muldiv_engine_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits.
module muldiv_engine_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           dividend_msb,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           qbit
);
    logic [WIDTH:0] rem_sh;

    assign rem_sh  = {rem_in[WIDTH-1:0], dividend_msb};
    assign qbit    = (rem_sh >= divisor);
    assign rem_out = qbit ? (rem_sh - divisor) : rem_sh;
endmodule

// File: rtl/muldiv_engine.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, MIPS sign rules)
// producing HI/LO; results register only in FINISH and hold until the next op.
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc is one bit wider so Booth survives M = most-negative and holds the remainder
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic             sa_q, sa_d;
    logic             sdiff_q, sdiff_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dzo_q, dzo_d;

    logic [WIDTH:0]   sum, rem_nxt;
    logic             qbit;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

    muldiv_engine_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (acc_q),
        .dividend_msb (q_q[WIDTH-1]),
        .divisor      (m_q),
        .rem_out      (rem_nxt),
        .qbit         (qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        sa_d    = sa_q;
        sdiff_d = sdiff_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        sum     = acc_q;
        case (state_q)
            ST_IDLE: begin
                // done_q marks the done cycle, which still counts as busy
                if (!done_q && (mult_start || div_start)) begin
                    cnt_d = CNT_W'(WIDTH);
                    dz_d  = 1'b0;
                    if (mult_start) begin
                        state_d = ST_MULT;
                        acc_d   = '0;
                        q_d     = op_b;
                        q1_d    = 1'b0;
                        m_d     = {op_a[WIDTH-1], op_a};
                    end else if (op_b == '0) begin
                        state_d = ST_FINISH;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                        acc_d   = '0;
                        q_d     = abs_a;
                        m_d     = {1'b0, abs_b};
                        sa_d    = op_a[WIDTH-1];
                        sdiff_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    end
                end
            end
            ST_MULT: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                acc_d = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
            end
            ST_DIV: begin
                acc_d = rem_nxt;
                q_d   = {q_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                q_d     = sdiff_q ? -q_q : q_q;
                acc_d   = {1'b0, sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (!dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end
                done_d  = 1'b1;
                dzo_d   = dz_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            sa_q    <= 1'b0;
            sdiff_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            sa_q    <= sa_d;
            sdiff_q <= sdiff_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign busy     = (state_q != ST_IDLE) || done_q;
endmodule

// File: tb/tb_muldiv_engine.sv
// Directed bench for muldiv_engine: vector table of mult/div ops plus hand-written
// sequences for reset, ignored starts and start priority.
module tb_muldiv_engine;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] op_a, op_b;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_engine dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_div;
        logic [31:0] a, b;
        logic [31:0] hi, lo;
        int          lat;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives a start pulse, returns cycles from the accepting edge to done (-1 on timeout)
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        mult_start = m; div_start = d; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        mult_start = 1'b0; div_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, nd;
        reset = 1'b0; mult_start = 1'b0; div_start = 1'b0; op_a = '0; op_b = '0;

        vecs.push_back('{"mul 7*-3",       1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MULT_LAT, 1'b0});
        vecs.push_back('{"mul min*min",    1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_LAT, 1'b0});
        vecs.push_back('{"mul -1*-1",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, MULT_LAT, 1'b0});
        vecs.push_back('{"mul max*max",    1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULT_LAT, 1'b0});
        vecs.push_back('{"mul 2^16*2^16",  1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MULT_LAT, 1'b0});
        vecs.push_back('{"div -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT,  1'b0});
        vecs.push_back('{"div min/-1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT,  1'b0});
        vecs.push_back('{"div 7/-2",       1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT,  1'b0});
        vecs.push_back('{"div 100/7",      1'b1, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, DIV_LAT,  1'b0});
        vecs.push_back('{"div -100/-7",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, DIV_LAT,  1'b0});
        vecs.push_back('{"div 3/5",        1'b1, 32'd3,        32'd5,        32'h0000_0003, 32'h0000_0000, DIV_LAT,  1'b0});
        vecs.push_back('{"div -1/min",     1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT,  1'b0});
        vecs.push_back('{"div 5/2 preload",1'b1, 32'd5,        32'd2,        32'h0000_0001, 32'h0000_0002, DIV_LAT,  1'b0});
        vecs.push_back('{"div 5/0",        1'b1, 32'd5,        32'd0,        32'h0000_0001, 32'h0000_0002, DIVZ_LAT, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst hi", hi_out, 0);
        chk("rst lo", lo_out, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst dz", {31'd0, div_zero}, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, lat);
            chk({vecs[i].name, " lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, " hi"}, hi_out, vecs[i].hi);
            chk({vecs[i].name, " lo"}, lo_out, vecs[i].lo);
            chk({vecs[i].name, " dz"}, {31'd0, div_zero}, {31'd0, vecs[i].dz});
            chk({vecs[i].name, " busy@done"}, {31'd0, busy}, 1);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " done pulse"}, {31'd0, done}, 0);
            chk({vecs[i].name, " hold lo"}, lo_out, vecs[i].lo);
        end

        // div_start during a divide must be dropped, not queued
        @(negedge clk);
        div_start = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 10) begin
                div_start = 1'b1; op_a = 32'd1; op_b = 32'd0;
            end else begin
                div_start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        div_start = 1'b0;
        chk("ignore lat", lat, DIV_LAT);
        chk("ignore lo", lo_out, 32'd14);
        chk("ignore hi", hi_out, 32'd2);
        chk("ignore dz", {31'd0, div_zero}, 0);
        count_dones(40, nd);
        chk("ignore no extra done", nd, 0);

        // both starts: multiply wins (divide of 6/3 would give lo=2)
        run_op(1'b1, 1'b1, 32'd6, 32'd3, lat);
        chk("both lat", lat, MULT_LAT);
        chk("both lo", lo_out, 32'd18);
        chk("both hi", hi_out, 32'd0);
        @(posedge clk);

        // reset in the middle of a multiply
        @(negedge clk);
        mult_start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst hi", hi_out, 0);
        chk("midrst lo", lo_out, 0);
        chk("midrst busy", {31'd0, busy}, 0);
        chk("midrst done", {31'd0, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        count_dones(40, nd);
        chk("midrst no done", nd, 0);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, lat);
        chk("post rst lat", lat, MULT_LAT);
        chk("post rst lo", lo_out, 32'd12);
        chk("post rst hi", hi_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
